// File: rtl/servo_pkg.sv
// servo_pkg: shared defaults, sequencer state encoding and width clamp for the servo sequencer
package servo_pkg;
  localparam int unsigned DEF_PWM_PERIOD = 1000000;
  localparam int unsigned DEF_MIN_HIGH   = 50000;
  localparam int unsigned DEF_MAX_HIGH   = 100000;
  localparam int unsigned DEF_CENTER     = 75000;
  localparam int unsigned DEF_MAX_STEP   = 500;
  typedef enum logic [1:0] {IDLE, RUN, UPDATE} state_e;
  function automatic int unsigned clamp(input int unsigned w, input int unsigned lo, input int unsigned hi);
    return w < lo ? lo : w > hi ? hi : w;
  endfunction
endpackage

// File: rtl/servo_sequencer_slew.sv
// servo_slew: one channel's target/active widths, per-frame bounded slew and registered PWM compare
module servo_slew import servo_pkg::*; #(
  parameter int unsigned CNT_W    = 20,
  parameter int unsigned MIN_HIGH = DEF_MIN_HIGH,
  parameter int unsigned MAX_HIGH = DEF_MAX_HIGH,
  parameter int unsigned CENTER   = DEF_CENTER,
  parameter int unsigned MAX_STEP = DEF_MAX_STEP
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we_i,
  input  logic [CNT_W-1:0] width_i,
  input  logic             update_i,
  input  logic             run_i,
  input  logic [CNT_W-1:0] cnt_i,
  output logic             pwm_o,
  output logic             diff_o
);
  localparam logic [CNT_W-1:0] STEP = CNT_W'(MAX_STEP);
  logic [CNT_W-1:0] target_q, target_d, active_q, active_d;
  logic up;
  assign up = target_q > active_q;
  assign diff_o = active_q != target_q;
  always_comb begin
    target_d = we_i ? CNT_W'(clamp(32'(width_i), MIN_HIGH, MAX_HIGH)) : target_q;
    // compare before subtracting so neither direction can wrap
    active_d = !update_i ? active_q
             : up ? (target_q - active_q <= STEP ? target_q : active_q + STEP)
             : (active_q - target_q <= STEP ? target_q : active_q - STEP);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      target_q <= CNT_W'(CENTER);
      active_q <= CNT_W'(CENTER);
      pwm_o    <= 1'b0;
    end else begin
      target_q <= target_d;
      active_q <= active_d;
      pwm_o    <= run_i && cnt_i < active_q;
    end
endmodule

// File: rtl/servo_sequencer.sv
// servo_sequencer: shared frame counter, frame FSM and command decode driving NUM_CH slewing servo PWM channels
module servo_sequencer import servo_pkg::*; #(
  parameter int unsigned NUM_CH     = 5,
  parameter int unsigned CH_W       = 3,
  parameter int unsigned CNT_W      = 20,
  parameter int unsigned PWM_PERIOD = DEF_PWM_PERIOD,
  parameter int unsigned MIN_HIGH   = DEF_MIN_HIGH,
  parameter int unsigned MAX_HIGH   = DEF_MAX_HIGH,
  parameter int unsigned CENTER     = DEF_CENTER,
  parameter int unsigned MAX_STEP   = DEF_MAX_STEP
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [CH_W-1:0]   cmd_ch,
  input  logic [CNT_W-1:0]  cmd_width,
  output logic              cmd_err,
  output logic [NUM_CH-1:0] pwm_out,
  output logic              frame_start,
  output logic              busy
);
  state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [NUM_CH-1:0] diff;
  logic rdy_q, err_q, fs_q, busy_q, upd, acc, run;
  assign upd = state_q == UPDATE;
  assign cmd_ready = rdy_q && !upd;
  assign acc = cmd_valid && cmd_ready;
  assign run = enable && state_q != IDLE;
  assign cmd_err = err_q;
  assign frame_start = fs_q;
  assign busy = busy_q;
  // UPDATE occupies the last counter value of a frame, so it is entered from counter PERIOD-2
  always_comb begin
    state_d = !enable ? IDLE : state_q == RUN && cnt_q == CNT_W'(PWM_PERIOD - 2) ? UPDATE : RUN;
    cnt_d = !enable || state_q != RUN ? '0 : cnt_q + CNT_W'(1);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rdy_q   <= 1'b0;
      err_q   <= 1'b0;
      fs_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdy_q   <= 1'b1;
      err_q   <= acc && 32'(cmd_ch) >= NUM_CH;
      fs_q    <= run && cnt_q == '0;
      busy_q  <= |diff;
    end
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    servo_slew #(
      .CNT_W(CNT_W), .MIN_HIGH(MIN_HIGH), .MAX_HIGH(MAX_HIGH), .CENTER(CENTER), .MAX_STEP(MAX_STEP)
    ) u_slew (
      .clk(clk),
      .rst_n(rst_n),
      .we_i(acc && 32'(cmd_ch) == i),
      .width_i(cmd_width),
      .update_i(upd),
      .run_i(run),
      .cnt_i(cnt_q),
      .pwm_o(pwm_out[i]),
      .diff_o(diff[i])
    );
  end
endmodule

// File: tb/tb_servo_sequencer.sv
// tb_servo_sequencer: directed scenarios plus random commands checked against a frame-position reference model
module tb_servo_sequencer;
  localparam int NUM_CH = 5, CH_W = 3, CNT_W = 20;
  localparam int P = 1000, MIN_H = 50, MAX_H = 100, CTR = 75, STEP = 5;
  logic clk = 0, rst_n = 1, enable = 0, cmd_valid = 0;
  logic [CH_W-1:0] cmd_ch = '0;
  logic [CNT_W-1:0] cmd_width = '0;
  logic cmd_ready, cmd_err, frame_start, busy;
  logic [NUM_CH-1:0] pwm_out;
  int checks = 0, failures = 0;
  int tgt[NUM_CH], act[NUM_CH], fw[NUM_CH];
  int pos;
  bit started, last_acc, e_fs, e_err, e_busy;
  logic [NUM_CH-1:0] e_pwm;

  servo_sequencer #(
    .NUM_CH(NUM_CH), .CH_W(CH_W), .CNT_W(CNT_W), .PWM_PERIOD(P),
    .MIN_HIGH(MIN_H), .MAX_HIGH(MAX_H), .CENTER(CTR), .MAX_STEP(STEP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_ch(cmd_ch), .cmd_width(cmd_width), .cmd_err(cmd_err), .pwm_out(pwm_out),
    .frame_start(frame_start), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int clampw(input int w);
    return w < MIN_H ? MIN_H : w > MAX_H ? MAX_H : w;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NUM_CH; i++) begin tgt[i] = CTR; act[i] = CTR; end
    pos = -1; started = 0; last_acc = 0; e_fs = 0; e_err = 0; e_busy = 0; e_pwm = '0;
  endtask

  // pos = counter value inside a running frame, -1 while idle
  task automatic step();
    bit upd, ready, acc;
    int d;
    @(posedge clk);
    upd = pos == P - 1;
    ready = started && !upd;
    acc = cmd_valid && ready;
    e_busy = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (act[i] != tgt[i]) e_busy = 1;
      e_pwm[i] = enable && pos >= 0 && pos < act[i];
    end
    e_fs = enable && pos == 0;
    e_err = acc && cmd_ch >= NUM_CH;
    if (acc && cmd_ch < NUM_CH) tgt[cmd_ch] = clampw(int'(cmd_width));
    if (upd)
      for (int i = 0; i < NUM_CH; i++) begin
        d = tgt[i] - act[i];
        act[i] = (d <= STEP && d >= -STEP) ? tgt[i] : act[i] + (d > 0 ? STEP : -STEP);
      end
    pos = !enable ? -1 : pos < 0 ? 0 : (pos + 1) % P;
    last_acc = acc;
    started = 1;
    @(negedge clk);
    check("pwm", 32'(pwm_out), 32'(e_pwm));
    check("frame_start", 32'(frame_start), 32'(e_fs));
    check("cmd_err", 32'(cmd_err), 32'(e_err));
    check("busy", 32'(busy), 32'(e_busy));
    check("cmd_ready", 32'(cmd_ready), 32'(started && pos != P - 1));
  endtask

  task automatic run_to(input int p);
    for (int n = 0; n < 3 * P && pos != p; n++) step();
    checks++;
    if (pos != p) begin failures++; $display("FAIL run_to: got pos %0d expected %0d", pos, p); end
  endtask

  task automatic send(input int ch, input int w);
    cmd_valid = 1; cmd_ch = CH_W'(ch); cmd_width = CNT_W'(w);
    step();
    for (int n = 0; n < 4 && !last_acc; n++) step();
    check("accept", 32'(last_acc), 1);
    cmd_valid = 0;
  endtask

  task automatic frame_widths();
    for (int n = 0; n < 2 * P && !frame_start; n++) step();
    check("frame_seen", 32'(frame_start), 1);
    for (int i = 0; i < NUM_CH; i++) fw[i] = int'(pwm_out[i]);
    repeat (P - 1) begin
      step();
      for (int i = 0; i < NUM_CH; i++) fw[i] += int'(pwm_out[i]);
    end
  endtask

  initial begin
    int exp2[4] = '{80, 85, 90, 90};
    model_reset();
    #1 rst_n = 0;
    #2;
    check("rst_pwm", 32'(pwm_out), 0);
    check("rst_fs", 32'(frame_start), 0);
    check("rst_err", 32'(cmd_err), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_ready", 32'(cmd_ready), 0);
    @(negedge clk); @(negedge clk);
    rst_n = 1;
    step();
    enable = 1;
    // idle center widths
    repeat (2) begin
      frame_widths();
      for (int i = 0; i < NUM_CH; i++) check($sformatf("center_w%0d", i), fw[i], CTR);
    end
    check("idle_busy", 32'(busy), 0);
    // single channel slew up
    run_to(200);
    send(2, 90);
    step();
    check("busy_set", 32'(busy), 1);
    for (int k = 0; k < 4; k++) begin
      frame_widths();
      check($sformatf("ch2_frame%0d", k), fw[2], exp2[k]);
      check($sformatf("ch0_frame%0d", k), fw[0], CTR);
    end
    check("busy_clear", 32'(busy), 0);
    // clamping in both directions
    run_to(200);
    send(0, 200);
    send(1, 10);
    for (int k = 1; k <= 6; k++) begin
      frame_widths();
      check($sformatf("ch0_clamp%0d", k), fw[0], (CTR + STEP * k > MAX_H) ? MAX_H : CTR + STEP * k);
      check($sformatf("ch1_clamp%0d", k), fw[1], (CTR - STEP * k < MIN_H) ? MIN_H : CTR - STEP * k);
      check($sformatf("ch2_hold%0d", k), fw[2], 90);
    end
    // out-of-range channel
    run_to(300);
    send(7, 60);
    check("err_pulse", 32'(cmd_err), 1);
    check("err_ready", 32'(cmd_ready), 1);
    step();
    check("err_clear", 32'(cmd_err), 0);
    frame_widths();
    check("err_w0", fw[0], 100);
    check("err_w1", fw[1], 50);
    check("err_w2", fw[2], 90);
    check("err_w3", fw[3], 75);
    check("err_w4", fw[4], 75);
    // command held across the update cycle
    run_to(P - 1);
    check("upd_ready", 32'(cmd_ready), 0);
    cmd_valid = 1; cmd_ch = 3; cmd_width = 60;
    step();
    check("upd_not_acc", 32'(last_acc), 0);
    step();
    check("upd_acc", 32'(last_acc), 1);
    cmd_valid = 0;
    frame_widths();
    check("held_w3_a", fw[3], 75);
    frame_widths();
    check("held_w3_b", fw[3], 70);
    // enable drop mid-frame, then resume
    run_to(30);
    enable = 0;
    step();
    check("drop_pwm", 32'(pwm_out), 0);
    repeat (20) step();
    enable = 1;
    frame_widths();
    check("resume_w0", fw[0], 100);
    check("resume_w1", fw[1], 50);
    check("resume_w3", fw[3], 65);
    // random traffic and enable toggling
    repeat (8000) begin
      cmd_valid = $urandom_range(0, 15) == 0;
      cmd_ch = CH_W'($urandom_range(0, 7));
      cmd_width = CNT_W'($urandom_range(0, 200));
      if ($urandom_range(0, 1499) == 0) enable = !enable;
      step();
    end
    cmd_valid = 0;
    enable = 1;
    // asynchronous reset mid-frame
    run_to(40);
    #2 rst_n = 0;
    #1;
    check("arst_pwm", 32'(pwm_out), 0);
    check("arst_ready", 32'(cmd_ready), 0);
    check("arst_fs", 32'(frame_start), 0);
    check("arst_busy", 32'(busy), 0);
    model_reset();
    @(negedge clk);
    rst_n = 1;
    repeat (1200) step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
